// File: rtl/blake2_g_sched_if.sv
// Handshake and G-datapath bundle between the BLAKE2 core, the round scheduler and the shared G instance.
// The master side is the core plus the G datapath; the slave side is the scheduler.
interface blake2_g_sched_if;
  logic          init;
  logic [1023:0] v_in;
  logic [1023:0] m_in;
  logic          ready;
  logic [1023:0] v_out;
  logic          v_valid;
  logic [63:0]   g_a;
  logic [63:0]   g_b;
  logic [63:0]   g_c;
  logic [63:0]   g_d;
  logic [63:0]   g_m0;
  logic [63:0]   g_m1;
  logic [63:0]   g_a_prim;
  logic [63:0]   g_b_prim;
  logic [63:0]   g_c_prim;
  logic [63:0]   g_d_prim;

  modport master (
    output init, v_in, m_in, g_a_prim, g_b_prim, g_c_prim, g_d_prim,
    input  ready, v_out, v_valid, g_a, g_b, g_c, g_d, g_m0, g_m1
  );

  modport slave (
    input  init, v_in, m_in, g_a_prim, g_b_prim, g_c_prim, g_d_prim,
    output ready, v_out, v_valid, g_a, g_b, g_c, g_d, g_m0, g_m1
  );
endinterface

// File: rtl/blake2_g_sched.sv
// BLAKE2b round scheduler: drives one shared combinational G instance with one call per cycle,
// 8 calls per round for NUM_ROUNDS rounds, then presents the final working vector.
module blake2_g_sched #(
  parameter int NUM_ROUNDS = 12
) (
  input logic            clk,
  input logic            reset_n,
  blake2_g_sched_if.slave bus
);

  typedef enum logic {IDLE, ROUND} state_t;

  localparam logic [4:0] LAST_ROUND = 5'(NUM_ROUNDS - 1);

  state_t      state_q, state_d;
  logic [63:0] v_q [16];
  logic [63:0] v_d [16];
  logic [63:0] m_q [16];
  logic [63:0] m_d [16];
  logic [2:0]  step_q, step_d;
  logic [4:0]  round_q, round_d;
  logic        v_valid_q, v_valid_d;

  logic [3:0]    idxA, idxB, idxC, idxD;
  logic [3:0]    rowSel;
  logic [63:0]   sigmaRow;
  logic [2:0]    stepRev;
  logic [7:0]    sigmaPair;
  logic [1023:0] vOut;

  // Steps 0-3 are the column calls, steps 4-7 the diagonal calls.
  always_comb begin
    idxA = 4'd0;
    idxB = 4'd4;
    idxC = 4'd8;
    idxD = 4'd12;
    unique case (step_q)
      3'd0: begin idxA = 4'd0; idxB = 4'd4; idxC = 4'd8;  idxD = 4'd12; end
      3'd1: begin idxA = 4'd1; idxB = 4'd5; idxC = 4'd9;  idxD = 4'd13; end
      3'd2: begin idxA = 4'd2; idxB = 4'd6; idxC = 4'd10; idxD = 4'd14; end
      3'd3: begin idxA = 4'd3; idxB = 4'd7; idxC = 4'd11; idxD = 4'd15; end
      3'd4: begin idxA = 4'd0; idxB = 4'd5; idxC = 4'd10; idxD = 4'd15; end
      3'd5: begin idxA = 4'd1; idxB = 4'd6; idxC = 4'd11; idxD = 4'd12; end
      3'd6: begin idxA = 4'd2; idxB = 4'd7; idxC = 4'd8;  idxD = 4'd13; end
      3'd7: begin idxA = 4'd3; idxB = 4'd4; idxC = 4'd9;  idxD = 4'd14; end
      default: ;
    endcase
  end

  // SIGMA rows packed one nibble per entry, entry 0 in the top nibble.
  always_comb begin
    rowSel = (round_q >= 5'd10) ? 4'(round_q - 5'd10) : round_q[3:0];
    unique case (rowSel)
      4'd0:    sigmaRow = 64'h0123456789ABCDEF;
      4'd1:    sigmaRow = 64'hEA489FD61C02B753;
      4'd2:    sigmaRow = 64'hB8C052FDAE367194;
      4'd3:    sigmaRow = 64'h7931DCBE265A40F8;
      4'd4:    sigmaRow = 64'h905724AFE1BC683D;
      4'd5:    sigmaRow = 64'h2C6A0B834D75FE19;
      4'd6:    sigmaRow = 64'hC51FED4A0763928B;
      4'd7:    sigmaRow = 64'hDB7EC13950F4862A;
      4'd8:    sigmaRow = 64'h6FE9B308C2D714A5;
      4'd9:    sigmaRow = 64'hA2847615FB9E3CD0;
      default: sigmaRow = 64'h0123456789ABCDEF;
    endcase
    stepRev   = 3'd7 - step_q;
    sigmaPair = sigmaRow[{stepRev, 3'b000} +: 8];
  end

  always_comb begin
    vOut = '0;
    for (int i = 0; i < 16; i++) begin
      vOut[1023 - 64*i -: 64] = v_q[i];
    end
  end

  assign bus.g_a     = v_q[idxA];
  assign bus.g_b     = v_q[idxB];
  assign bus.g_c     = v_q[idxC];
  assign bus.g_d     = v_q[idxD];
  assign bus.g_m0    = m_q[sigmaPair[7:4]];
  assign bus.g_m1    = m_q[sigmaPair[3:0]];
  assign bus.ready   = (state_q == IDLE);
  assign bus.v_valid = v_valid_q;
  assign bus.v_out   = vOut;

  always_comb begin
    state_d   = state_q;
    step_d    = step_q;
    round_d   = round_q;
    v_valid_d = v_valid_q;
    for (int i = 0; i < 16; i++) begin
      v_d[i] = v_q[i];
      m_d[i] = m_q[i];
    end
    unique case (state_q)
      IDLE: begin
        if (bus.init) begin
          for (int i = 0; i < 16; i++) begin
            v_d[i] = bus.v_in[1023 - 64*i -: 64];
            m_d[i] = bus.m_in[1023 - 64*i -: 64];
          end
          step_d    = 3'd0;
          round_d   = 5'd0;
          v_valid_d = 1'b0;
          state_d   = ROUND;
        end
      end
      ROUND: begin
        v_d[idxA] = bus.g_a_prim;
        v_d[idxB] = bus.g_b_prim;
        v_d[idxC] = bus.g_c_prim;
        v_d[idxD] = bus.g_d_prim;
        if (step_q == 3'd7) begin
          step_d = 3'd0;
          // The final round's last call retires straight to IDLE, so round never passes LAST_ROUND.
          if (round_q == LAST_ROUND) begin
            state_d   = IDLE;
            v_valid_d = 1'b1;
          end else begin
            round_d = round_q + 5'd1;
          end
        end else begin
          step_d = step_q + 3'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      step_q    <= 3'd0;
      round_q   <= 5'd0;
      v_valid_q <= 1'b0;
      for (int i = 0; i < 16; i++) begin
        v_q[i] <= 64'd0;
        m_q[i] <= 64'd0;
      end
    end else begin
      state_q   <= state_d;
      step_q    <= step_d;
      round_q   <= round_d;
      v_valid_q <= v_valid_d;
      for (int i = 0; i < 16; i++) begin
        v_q[i] <= v_d[i];
        m_q[i] <= m_d[i];
      end
    end
  end

endmodule

// File: tb/tb_blake2_g_sched.sv
// Bench for blake2_g_sched: schedule trace via an identity G stub, reset abort, and
// known-answer/back-to-back compressions through a behavioural BLAKE2b G.
module tb_blake2_g_sched;

  logic clk = 1'b0;
  logic reset_n;
  logic useRealG;
  int   checks = 0;
  int   errors = 0;
  int   callCount = 0;

  logic [63:0] logA  [0:1023];
  logic [63:0] logB  [0:1023];
  logic [63:0] logC  [0:1023];
  logic [63:0] logD  [0:1023];
  logic [63:0] logM0 [0:1023];
  logic [63:0] logM1 [0:1023];

  typedef struct {
    int callIdx;
    int ia, ib, ic, id;
    int im0, im1;
  } schedVec_t;

  schedVec_t vecs [11];

  localparam logic [63:0] IV0 = 64'h6A09E667F3BCC908;
  localparam logic [63:0] IV1 = 64'hBB67AE8584CAA73B;
  localparam logic [63:0] IV2 = 64'h3C6EF372FE94F82B;
  localparam logic [63:0] IV3 = 64'hA54FF53A5F1D36F1;
  localparam logic [63:0] IV4 = 64'h510E527FADE682D1;
  localparam logic [63:0] IV5 = 64'h9B05688C2B3E6C1F;
  localparam logic [63:0] IV6 = 64'h1F83D9ABFB41BD6B;
  localparam logic [63:0] IV7 = 64'h5BE0CD19137E2179;
  localparam logic [63:0] KAT_H0 = 64'h6A09E667F2BDC948;

  always #5 clk = ~clk;

  blake2_g_sched_if bus ();

  blake2_g_sched #(.NUM_ROUNDS(12)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  function automatic logic [63:0] rotr(input logic [63:0] x, input int n);
    return (x >> n) | (x << (64 - n));
  endfunction

  function automatic logic [255:0] gFunc(input logic [63:0] aIn, bIn, cIn, dIn, x, y);
    logic [63:0] a, b, c, d;
    a = aIn; b = bIn; c = cIn; d = dIn;
    a = a + b + x;  d = rotr(d ^ a, 32);
    c = c + d;      b = rotr(b ^ c, 24);
    a = a + b + y;  d = rotr(d ^ a, 16);
    c = c + d;      b = rotr(b ^ c, 63);
    return {a, b, c, d};
  endfunction

  // G stub: identity for schedule tracing, real BLAKE2b G for known-answer runs.
  logic [255:0] gRes;
  always_comb begin
    gRes = gFunc(bus.g_a, bus.g_b, bus.g_c, bus.g_d, bus.g_m0, bus.g_m1);
    if (useRealG)
      {bus.g_a_prim, bus.g_b_prim, bus.g_c_prim, bus.g_d_prim} = gRes;
    else
      {bus.g_a_prim, bus.g_b_prim, bus.g_c_prim, bus.g_d_prim} = {bus.g_a, bus.g_b, bus.g_c, bus.g_d};
  end

  always @(negedge clk) begin
    if (reset_n && !bus.ready && callCount < 1024) begin
      logA[callCount]  <= bus.g_a;
      logB[callCount]  <= bus.g_b;
      logC[callCount]  <= bus.g_c;
      logD[callCount]  <= bus.g_d;
      logM0[callCount] <= bus.g_m0;
      logM1[callCount] <= bus.g_m1;
      callCount        <= callCount + 1;
    end
  end

  function automatic logic [63:0] wordOf(input logic [1023:0] vec, input int i);
    return vec[1023 - 64*i -: 64];
  endfunction

  function automatic logic [63:0] vTag(input int i);
    return 64'hA5A5_0000_0000_0000 | 64'(i);
  endfunction

  function automatic logic [63:0] mTag(input int i);
    return 64'h3C3C_0000_0000_0100 | 64'(i);
  endfunction

  function automatic logic [1023:0] tagVec(input bit isMsg);
    logic [1023:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) r[1023 - 64*i -: 64] = isMsg ? mTag(i) : vTag(i);
    return r;
  endfunction

  function automatic logic [63:0] sigmaRowOf(input int row);
    case (row)
      0: return 64'h0123456789ABCDEF;
      1: return 64'hEA489FD61C02B753;
      2: return 64'hB8C052FDAE367194;
      3: return 64'h7931DCBE265A40F8;
      4: return 64'h905724AFE1BC683D;
      5: return 64'h2C6A0B834D75FE19;
      6: return 64'hC51FED4A0763928B;
      7: return 64'hDB7EC13950F4862A;
      8: return 64'h6FE9B308C2D714A5;
      default: return 64'hA2847615FB9E3CD0;
    endcase
  endfunction

  function automatic int sg(input logic [63:0] row, input int k);
    return int'(row[63 - 4*k -: 4]);
  endfunction

  function automatic logic [1023:0] gApply(input logic [1023:0] vv, input int a, b, c, d,
                                           input logic [63:0] x, y);
    logic [255:0] r;
    logic [1023:0] o;
    r = gFunc(wordOf(vv, a), wordOf(vv, b), wordOf(vv, c), wordOf(vv, d), x, y);
    o = vv;
    o[1023 - 64*a -: 64] = r[255:192];
    o[1023 - 64*b -: 64] = r[191:128];
    o[1023 - 64*c -: 64] = r[127:64];
    o[1023 - 64*d -: 64] = r[63:0];
    return o;
  endfunction

  // Reference 12-round mixing loop written the usual software way.
  function automatic logic [1023:0] compressModel(input logic [1023:0] vIn, mIn);
    logic [1023:0] vv;
    logic [63:0]   m [16];
    logic [63:0]   row;
    vv = vIn;
    for (int i = 0; i < 16; i++) m[i] = wordOf(mIn, i);
    for (int r = 0; r < 12; r++) begin
      row = sigmaRowOf(r % 10);
      vv = gApply(vv, 0, 4,  8, 12, m[sg(row, 0)],  m[sg(row, 1)]);
      vv = gApply(vv, 1, 5,  9, 13, m[sg(row, 2)],  m[sg(row, 3)]);
      vv = gApply(vv, 2, 6, 10, 14, m[sg(row, 4)],  m[sg(row, 5)]);
      vv = gApply(vv, 3, 7, 11, 15, m[sg(row, 6)],  m[sg(row, 7)]);
      vv = gApply(vv, 0, 5, 10, 15, m[sg(row, 8)],  m[sg(row, 9)]);
      vv = gApply(vv, 1, 6, 11, 12, m[sg(row, 10)], m[sg(row, 11)]);
      vv = gApply(vv, 2, 7,  8, 13, m[sg(row, 12)], m[sg(row, 13)]);
      vv = gApply(vv, 3, 4,  9, 14, m[sg(row, 14)], m[sg(row, 15)]);
    end
    return vv;
  endfunction

  task automatic checkOutput(input string name, input logic [383:0] actual, input logic [383:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic checkVector(input string name, input logic [1023:0] actual, input logic [1023:0] expected);
    int firstBad;
    checks++;
    if (actual !== expected) begin
      errors++;
      firstBad = 0;
      for (int i = 15; i >= 0; i--) if (wordOf(actual, i) !== wordOf(expected, i)) firstBad = i;
      $display("[TB] FAIL %s: word %0d got %h expected %h", name, firstBad,
               wordOf(actual, firstBad), wordOf(expected, firstBad));
    end
  endtask

  task automatic waitIdle(output int cycles);
    cycles = 0;
    while (cycles < 300) begin
      @(negedge clk); #1;
      if (bus.ready) break;
      cycles++;
    end
  endtask

  // Starts a compression; at busy cycle pulseAt the second input set is driven (with an init pulse unless hold).
  task automatic applyStimulus(input logic [1023:0] vIn, mIn, v2, m2, input int pulseAt, input bit hold,
                               output int cycles, output int calls, output int base);
    @(negedge clk);
    bus.v_in = vIn;
    bus.m_in = mIn;
    bus.init = 1'b1;
    #1 base = callCount;
    @(posedge clk); #1;
    if (!hold) bus.init = 1'b0;
    cycles = 0;
    while (cycles < 300) begin
      @(negedge clk); #1;
      if (bus.ready) break;
      cycles++;
      if (cycles == pulseAt) begin
        bus.v_in = v2;
        bus.m_in = m2;
        if (!hold) bus.init = 1'b1;
      end else if (!hold) begin
        bus.init = 1'b0;
      end
    end
    calls = callCount - base;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [1023:0] katV, katM, abdM, res1, res2;
    logic [383:0]  expSched, actSched;
    int cycles, calls, base, k;

    vecs[0]  = '{0,  0, 4,  8, 12,  0,  1};
    vecs[1]  = '{4,  0, 5, 10, 15,  8,  9};
    vecs[2]  = '{7,  3, 4,  9, 14, 14, 15};
    vecs[3]  = '{8,  0, 4,  8, 12, 14, 10};
    vecs[4]  = '{13, 1, 6, 11, 12,  0,  2};
    vecs[5]  = '{19, 3, 7, 11, 15, 15, 13};
    vecs[6]  = '{46, 2, 7,  8, 13, 15, 14};
    vecs[7]  = '{79, 3, 4,  9, 14, 13,  0};
    vecs[8]  = '{80, 0, 4,  8, 12,  0,  1};
    vecs[9]  = '{90, 2, 6, 10, 14,  9, 15};
    vecs[10] = '{95, 3, 4,  9, 14,  5,  3};

    katV = {KAT_H0, IV1, IV2, IV3, IV4, IV5, IV6, IV7,
            IV0, IV1, IV2, IV3, IV4 ^ 64'd3, IV5, ~IV6, IV7};
    katM = {64'h0000000000636261, 960'd0};
    abdM = {64'h0000000000646261, 960'd0};

    useRealG = 1'b0;
    reset_n  = 1'b0;
    bus.init = 1'b0;
    bus.v_in = '0;
    bus.m_in = '0;
    #2;
    checkOutput("rstReady", bus.ready, 1);
    checkOutput("rstValid", bus.v_valid, 0);
    checkVector("rstVout", bus.v_out, '0);
    checkOutput("rstGA", bus.g_a, 0);
    @(negedge clk);
    reset_n = 1'b1;

    $display("[TB] schedule trace with identity G");
    applyStimulus(tagVec(0), tagVec(1), '0, '0, -1, 0, cycles, calls, base);
    checkOutput("traceLatency", cycles, 96);
    checkOutput("traceCalls", calls, 96);
    checkOutput("traceReady", bus.ready, 1);
    checkOutput("traceValid", bus.v_valid, 1);
    checkVector("traceVout", bus.v_out, tagVec(0));
    for (int i = 0; i < 11; i++) begin
      k = base + vecs[i].callIdx;
      expSched = {vTag(vecs[i].ia), vTag(vecs[i].ib), vTag(vecs[i].ic), vTag(vecs[i].id),
                  mTag(vecs[i].im0), mTag(vecs[i].im1)};
      actSched = {logA[k], logB[k], logC[k], logD[k], logM0[k], logM1[k]};
      checkOutput($sformatf("sched%0d", vecs[i].callIdx), actSched, expSched);
    end

    $display("[TB] reset abort at round 3 step 5");
    @(negedge clk);
    bus.v_in = tagVec(0);
    bus.m_in = tagVec(1);
    bus.init = 1'b1;
    #1 base = callCount;
    @(posedge clk); #1;
    bus.init = 1'b0;
    cycles = 0;
    while (callCount - base < 30 && cycles < 200) begin
      @(negedge clk); #1;
      cycles++;
    end
    k = base + 29;
    checkOutput("abortPoint", {logA[k], logB[k], logC[k], logD[k], logM0[k], logM1[k]},
                {vTag(1), vTag(6), vTag(11), vTag(12), mTag(5), mTag(10)});
    reset_n = 1'b0;
    #1;
    checkOutput("abortReady", bus.ready, 1);
    checkOutput("abortValid", bus.v_valid, 0);
    checkVector("abortVout", bus.v_out, '0);
    @(negedge clk);
    reset_n = 1'b1;

    $display("[TB] known answer with busy init pulse");
    useRealG = 1'b1;
    res1 = compressModel(katV, katM);
    applyStimulus(katV, katM, ~katV, ~katM, 40, 0, cycles, calls, base);
    checkOutput("katLatency", cycles, 96);
    checkOutput("katCalls", calls, 96);
    checkOutput("katValid", bus.v_valid, 1);
    checkOutput("katWord0", KAT_H0 ^ wordOf(bus.v_out, 0) ^ wordOf(bus.v_out, 8), 64'h0D4D1C983FA580BA);
    checkVector("katModel", bus.v_out, res1);

    $display("[TB] back-to-back with init held high");
    res2 = compressModel(katV, abdM);
    applyStimulus(katV, katM, katV, abdM, 10, 1, cycles, calls, base);
    checkOutput("b2bFirstLatency", cycles, 96);
    checkOutput("b2bFirstReady", bus.ready, 1);
    checkOutput("b2bFirstValid", bus.v_valid, 1);
    checkOutput("b2bFirstWord0", KAT_H0 ^ wordOf(bus.v_out, 0) ^ wordOf(bus.v_out, 8), 64'h0D4D1C983FA580BA);
    @(posedge clk); #1;
    bus.init = 1'b0;
    checkOutput("b2bSecondReady", bus.ready, 0);
    checkOutput("b2bSecondValid", bus.v_valid, 0);
    waitIdle(cycles);
    checkOutput("b2bSecondLatency", cycles, 96);
    checkOutput("b2bSecondDone", bus.v_valid, 1);
    checkVector("b2bSecondModel", bus.v_out, res2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/blake2_g_sched.md
Name: blake2_g_sched

Overview:
- Round scheduler for one shared, purely combinational BLAKE2b G-function instance.
- Captures the 16-word working vector v and the 16-word message block m.
- Issues one G call per cycle: 8 calls per round (4 column, 4 diagonal) for NUM_ROUNDS rounds, selecting message words via the BLAKE2 SIGMA table, then presents the final v.
- Sits between the BLAKE2 core control (init, h/t/f handling, finalisation XOR) and the G datapath instance.

Parameters:
- NUM_ROUNDS, 12, number of rounds per compression; legal 1..16.

Ports:
- clk  in  1  system clock, all state on rising edge
- reset_n  in  1  asynchronous active-low reset
- init  in  1  start pulse; sampled only when ready=1
- v_in  in  1024  initial working vector; v0 in bits [1023:960], v15 in [63:0]
- m_in  in  1024  message block; m0 in bits [1023:960], m15 in [63:0]
- ready  out  1  1 = idle, init accepted
- v_out  out  1024  final working vector, same packing as v_in
- v_valid  out  1  v_out holds the result of the last completed compression
- g_a, g_b, g_c, g_d  out  64 each  G operand words
- g_m0, g_m1  out  64 each  G message words
- g_a_prim, g_b_prim, g_c_prim, g_d_prim  in  64 each  G results, combinational from the g_* outputs

Behaviour:
- Reset (asynchronous, reset_n=0):
  - state=IDLE, ready=1, v_valid=0.
  - v registers, m registers, round and step counters all 0.
  - v_out=0; g_* outputs are 0 as they derive from zeroed registers.
- States: IDLE, ROUND.
- IDLE:
  - ready=1.
  - init=1 at edge E0: load v_reg<=v_in and m_reg<=m_in; round<=0, step<=0; v_valid<=0; go to ROUND.
  - init=0: hold, no change.
- ROUND:
  - ready=0; init is ignored.
  - Each edge writes g_a_prim..g_d_prim back into v_reg at the current (a,b,c,d) indices.
  - Then step increments 0..7; at step 7, step<=0 and round increments.
- Index map (combinational from step):
  - s0:(0,4,8,12), s1:(1,5,9,13), s2:(2,6,10,14), s3:(3,7,11,15)
  - s4:(0,5,10,15), s5:(1,6,11,12), s6:(2,7,8,13), s7:(3,4,9,14)
  - g_a..g_d = v_reg at those indices.
- Message select:
  - row = round mod 10, from the standard BLAKE2 SIGMA table (RFC 7693 sec 2.7), hard-coded.
  - g_m0 = m_reg[SIGMA[row][2*step]]; g_m1 = m_reg[SIGMA[row][2*step+1]].
- Termination:
  - On the edge completing round=NUM_ROUNDS-1, step=7: go to IDLE, ready<=1, v_valid<=1.
  - No extra cycles: the completing edge is E(8*NUM_ROUNDS) after E0, i.e. E96 by default.
  - init may be accepted on the very next edge after ready rises; this clears v_valid.
- v_out = v_reg continuously. It is meaningful only while v_valid=1 and holds until the next accepted init.
- Counters: step 3 bits, round 5 bits. Round never exceeds NUM_ROUNDS-1 while in ROUND.
- All 64-bit arithmetic lives in G; this block does no arithmetic beyond counter increments.
- Reset asserted mid-ROUND: immediate abort to the reset values above; no partial result is flagged valid.
- init held high across completion: a new compression starts on the edge after ready=1. This is legal back-to-back operation.
- m_in and v_in are sampled only at E0 and may change freely afterwards.

Test Plan:
- Reset: assert reset_n=0 mid-ROUND at step 5, round 3 -> same cycle ready=1, v_valid=0, v_out=0; the next init is accepted normally.
- Schedule trace with a G stub that returns inputs unchanged and logs indices:
  - first call (v0,v4,v8,v12) with m0=m[0], m1=m[1]; call 4 is (v0,v5,v10,v15).
  - round 1 step 0: g_m0=m[14], g_m1=m[10].
  - round 10 step 0: g_m0=m[0], g_m1=m[1] (row wrap).
- Latency: init at E0 -> ready=0 from E0 through E95, ready=1 and v_valid=1 after E96; exactly 96 G calls logged.
- Ignore while busy: pulse init at step 40 with different v_in/m_in -> result unchanged, exactly 96 calls.
- Known answer with real blake2_G: load RFC 7693 App. A "abc" state (t=3, final block) -> h0 ^ v0 ^ v8 = 64'h0D4D1C983FA580BA, the first digest word BA80A53F981C4D0D.
- Back-to-back: init held high for two compressions -> second starts the cycle after the first ready; v_valid drops at the second E0 and rises again 96 cycles later with the correct second result.
